// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions for the issue front end: opcodes, instruction layout
// and the issue-controller state encoding.
package gpu_isa_pkg;

    localparam logic [2:0] OP_IADD = 3'b000;
    localparam logic [2:0] OP_ISUB = 3'b001;
    localparam logic [2:0] OP_IMUL = 3'b010;
    localparam logic [2:0] OP_IDIV = 3'b011;
    localparam logic [2:0] OP_FADD = 3'b100;
    localparam logic [2:0] OP_FSUB = 3'b101;
    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    // Register number driven to func_unit when nothing is being issued
    localparam logic [4:0] REG_IDLE = 5'h1F;

    // Encoded instruction word, MSB first
    typedef struct packed {
        logic [2:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [5:0] shammt;
        logic [7:0] rsvd;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_LATCH,
        ST_EXEC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder.
// Ports: imem_rdata (raw word) -> instr_c (field view), is_illegal_c (LOAD
// inside a program), is_end_c (NOP/end marker).
module instr_decode
    import gpu_isa_pkg::*;
(
    input  logic [31:0] imem_rdata,
    output instr_t      instr_c,
    output logic        is_illegal_c,
    output logic        is_end_c
);

    always_comb begin
        instr_c      = instr_t'(imem_rdata);
        is_end_c     = (instr_c.opcode == OP_NOP);
        is_illegal_c = (instr_c.opcode == OP_LOAD);
    end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Front-end issue controller for one func_unit lane.
// Control: clk, rst (async, active high), start, abort, base_pc, instr_count.
// Instruction memory: imem_rd_en, imem_addr out; imem_rdata in (1-cycle latency).
// func_unit: type_instruction, regnum_1, regnum_2, dest_reg, shammt, is_active
// out; thread_complete, final_result in.
// Writeback/status: result_valid, result_data, result_dest, busy, done, error.
module instr_issue_ctrl
    import gpu_isa_pkg::*;
#(
    parameter int unsigned IMEM_AW        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [IMEM_AW-1:0] base_pc,
    input  logic [CNT_W-1:0]   instr_count,
    output logic               imem_rd_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [2:0]         type_instruction,
    output logic [4:0]         regnum_1,
    output logic [4:0]         regnum_2,
    output logic [4:0]         dest_reg,
    output logic [5:0]         shammt,
    output logic               is_active,
    input  logic               thread_complete,
    input  logic [31:0]        final_result,
    output logic               result_valid,
    output logic [31:0]        result_data,
    output logic [4:0]         result_dest,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state;
    logic [IMEM_AW-1:0]   pc;
    logic [CNT_W-1:0]     target;
    logic [CNT_W-1:0]     executed;
    logic [TMR_W-1:0]     timer;

    logic [IMEM_AW-1:0]   pc_next;
    logic [CNT_W-1:0]     exec_next;

    instr_t               dec;
    logic                 dec_illegal;
    logic                 dec_end;
    logic                 unused_rsvd;

    instr_decode u_decode (
        .imem_rdata   (imem_rdata),
        .instr_c      (dec),
        .is_illegal_c (dec_illegal),
        .is_end_c     (dec_end)
    );

    // Low byte of the instruction word carries no information
    assign unused_rsvd = ^dec.rsvd;

    // pc wraps naturally at the address width
    assign pc_next   = pc + IMEM_AW'(1);
    assign exec_next = executed + CNT_W'(1);

    // Issue FSM; every output is a register updated on the state transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            pc               <= '0;
            target           <= '0;
            executed         <= '0;
            timer            <= '0;
            imem_rd_en       <= 1'b0;
            imem_addr        <= '0;
            type_instruction <= OP_NOP;
            regnum_1         <= REG_IDLE;
            regnum_2         <= REG_IDLE;
            dest_reg         <= REG_IDLE;
            shammt           <= '0;
            is_active        <= 1'b0;
            result_valid     <= 1'b0;
            result_data      <= '0;
            result_dest      <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            // Single-cycle strobes
            result_valid <= 1'b0;
            done         <= 1'b0;
            imem_rd_en   <= 1'b0;

            if (abort) begin
                // Back to reset drive; error and captured result are kept
                state            <= ST_IDLE;
                imem_addr        <= '0;
                type_instruction <= OP_NOP;
                regnum_1         <= REG_IDLE;
                regnum_2         <= REG_IDLE;
                dest_reg         <= REG_IDLE;
                shammt           <= '0;
                is_active        <= 1'b0;
                busy             <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            pc               <= base_pc;
                            target           <= instr_count;
                            executed         <= '0;
                            timer            <= '0;
                            error            <= 1'b0;
                            type_instruction <= OP_LOAD;
                            is_active        <= 1'b1;
                            busy             <= 1'b1;
                            state            <= ST_LOAD;
                        end
                    end

                    ST_LOAD: begin
                        type_instruction <= OP_NOP;
                        if (target == '0) begin
                            done      <= 1'b1;
                            is_active <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            imem_rd_en <= 1'b1;
                            imem_addr  <= pc;
                            state      <= ST_FETCH;
                        end
                    end

                    ST_FETCH: begin
                        state <= ST_LATCH;
                    end

                    ST_LATCH: begin
                        if (dec_end || dec_illegal) begin
                            error     <= dec_illegal;
                            done      <= 1'b1;
                            is_active <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            type_instruction <= dec.opcode;
                            regnum_1         <= dec.rs1;
                            regnum_2         <= dec.rs2;
                            dest_reg         <= dec.rd;
                            shammt           <= dec.shammt;
                            timer            <= '0;
                            state            <= ST_EXEC;
                        end
                    end

                    ST_EXEC: begin
                        // Completion is checked first so it beats a same-cycle timeout
                        if (thread_complete) begin
                            result_valid     <= 1'b1;
                            result_data      <= final_result;
                            result_dest      <= dest_reg;
                            type_instruction <= OP_NOP;
                            regnum_1         <= REG_IDLE;
                            regnum_2         <= REG_IDLE;
                            dest_reg         <= REG_IDLE;
                            shammt           <= '0;
                            pc               <= pc_next;
                            executed         <= exec_next;
                            if (exec_next == target) begin
                                done      <= 1'b1;
                                is_active <= 1'b0;
                                state     <= ST_DONE;
                            end else begin
                                imem_rd_en <= 1'b1;
                                imem_addr  <= pc_next;
                                state      <= ST_FETCH;
                            end
                        end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                            // This is the last permitted EXEC cycle
                            error            <= 1'b1;
                            type_instruction <= OP_NOP;
                            regnum_1         <= REG_IDLE;
                            regnum_2         <= REG_IDLE;
                            dest_reg         <= REG_IDLE;
                            shammt           <= '0;
                            done             <= 1'b1;
                            is_active        <= 1'b0;
                            state            <= ST_DONE;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end

                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/instr_issue_ctrl.md
Name: instr_issue_ctrl

Overview:
- Front-end issue controller that drives func_unit.
- After start, asserts the register-file load opcode once, then fetches encoded instructions from instruction memory and issues them one at a time on func_unit's operand/opcode inputs.
- Waits for thread_complete on each instruction and forwards final_result, tagged with its destination register, to the writeback/trace side.
- Sits between the per-thread program memory and one func_unit lane.

Parameters:
- IMEM_AW, 8, instruction memory address width.
- TIMEOUT_CYCLES, 64, maximum EXEC cycles allowed per instruction before error.
- CNT_W, 9, width of instr_count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin program; sampled in IDLE only
- abort  in  1  return to IDLE from any state
- base_pc  in  IMEM_AW  first instruction address; latched on start
- instr_count  in  CNT_W  number of instructions to run; latched on start
- imem_rd_en  out  1  instruction memory read strobe
- imem_addr  out  IMEM_AW  read address
- imem_rdata  in  32  instruction word, valid 1 cycle after imem_rd_en
- type_instruction  out  3  func_unit opcode
- regnum_1  out  5  source register 1
- regnum_2  out  5  source register 2
- dest_reg  out  5  destination register
- shammt  out  6  shift amount
- is_active  out  1  thread active to func_unit
- thread_complete  in  1  func_unit operation done (sampled in EXEC)
- final_result  in  32  func_unit result
- result_valid  out  1  one-cycle pulse: result_data/result_dest valid
- result_data  out  32  captured final_result
- result_dest  out  5  dest_reg of the captured result
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at program end
- error  out  1  sticky until next start: illegal opcode or timeout

Behaviour:
- Instruction encoding:
  - [31:29] opcode
  - [28:24] rd
  - [23:19] rs1
  - [18:14] rs2
  - [13:8] shammt
  - [7:0] ignored
- Opcodes:
  - 000 iadd, 001 isub, 010 imul, 011 idiv, 100 fadd, 101 fsub: issued.
  - 110 LOAD: illegal inside a program.
  - 111 NOP/end: terminates the program.
- Reset values:
  - type_instruction=3'b111; regnum_1, regnum_2, dest_reg=5'h1F; shammt=0.
  - is_active, imem_rd_en, result_valid, busy, done, error = 0.
  - result_data=0, result_dest=0, imem_addr=0; state IDLE.
- Idle drive: whenever no instruction is being issued, type_instruction=111.
- States:
  - IDLE: on start, latch base_pc into pc, latch instr_count, clear counter and error, go to LOAD.
  - LOAD: type_instruction=110 for exactly 1 cycle; is_active=1. Go to DONE if instr_count==0, else FETCH.
  - FETCH: imem_rd_en=1, imem_addr=pc for 1 cycle; go to LATCH.
  - LATCH: decode imem_rdata.
    - Opcode 111: go to DONE; nothing is issued.
    - Opcode 110: set error and go to DONE.
    - Otherwise: register the fields onto the func_unit outputs and go to EXEC.
  - EXEC: hold the fields stable and increment the timeout counter. On thread_complete=1:
    - Next cycle: result_valid=1, result_data=final_result, result_dest=dest_reg.
    - Outputs return to the idle drive; pc wraps modulo 2^IMEM_AW; executed++.
    - If executed==instr_count go to DONE, else FETCH.
  - EXEC timeout: if the counter reaches TIMEOUT_CYCLES without thread_complete, set error and go to DONE.
  - DONE: done=1 for 1 cycle, is_active=0, go to IDLE.
- Latency:
  - Fields are first valid 2 cycles after FETCH.
  - Minimum per-instruction period is 4 cycles (FETCH, LATCH, EXEC ≥1, transition).
- is_active=1 in LOAD, FETCH, LATCH and EXEC; 0 otherwise.
- thread_complete outside EXEC is ignored.
- start while busy is ignored.
- abort takes priority over all transitions:
  - Next state IDLE; outputs return to reset values except error and result_*.
  - No done pulse; no result_valid for the in-flight instruction.
- Simultaneous thread_complete and timeout in the same cycle: completion wins, no error.
- Async rst mid-program immediately forces all reset values.

Decomposition:
- Shared package gpu_isa_pkg holds:
  - opcode localparams (OP_IADD … OP_LOAD=3'b110, OP_NOP=3'b111);
  - a packed struct instr_t with the field layout above;
  - the FSM state enum.
- One natural sub-module, instr_decode: purely combinational, imem_rdata → instr_t plus is_illegal/is_end flags.

Test Plan:
- Reset: assert rst mid-EXEC → type_instruction=111 and is_active=0 immediately; busy=0 and error=0.
- Load then add:
  - Setup: base_pc=0, instr_count=1, imem[0]={000,rd=5,rs1=2,rs2=4}; func_unit model loaded with reg[i]=i.
  - Expect: one cycle of 110, then fields 000/2/4/5.
  - Expect: result_valid with result_data=6, result_dest=5, then done pulse with error=0.
- Six-op program:
  - Program: add 2,4→5; sub 7,6→8; mul 10,11→12; div 14,15→16; fadd 18,19→20; fsub 21,22→23.
  - Expect 6 result_valid pulses in order with dests 5, 8, 12, 16, 20, 23.
  - Expect integer results 6, 1, 110, 0; then done.
- Early end: instr_count=4 with imem[1]=111 → exactly 1 result, done after the LATCH of address 1, error=0.
- Faults:
  - Opcode 110 at imem[0] → error=1, no result_valid, done.
  - Model never raises thread_complete → error after 64 EXEC cycles.
- Edges:
  - instr_count=0 → LOAD then done, no imem_rd_en.
  - base_pc=255, instr_count=2 → addresses 255 then 0.
  - abort during EXEC → IDLE, no done.
